l2_request_arbiter: RTL
=======================

// Module: l2_request_arbiter
// PURPOSE
//  Shares the single unified L2 cache port between the L1 I-cache and L1 D-cache miss paths.
//  Accepts line-granular requests from both L1s, selects one, and latches its address/data.
//  Holds the L2 request until the L2 answers, then returns the response to the winner only.
//  Sits between the two L1 cache controllers and l2_cache_control; one transaction in flight.
// PARAMETERS
//  ADDR_WIDTH   32   line address width (low 5 bits are zero for a 256-bit line)
//  LINE_WIDTH   256  cache line width in bits
//  MAX_D_STREAK 4    consecutive D grants allowed while I is waiting before I is forced; >=1
// PORTS
//  clk           in   1           system clock
//  rst           in   1           synchronous active-high reset
//  i_read        in   1           I-cache line read request (level; held until i_resp)
//  i_address     in   ADDR_WIDTH  I-cache line address
//  i_rdata       out  LINE_WIDTH  line returned to I-cache (valid with i_resp)
//  i_resp        out  1           one-cycle I-cache completion pulse
//  d_read        in   1           D-cache line read request (level; held until d_resp)
//  d_write       in   1           D-cache line writeback request (level; held until d_resp)
//  d_address     in   ADDR_WIDTH  D-cache line address
//  d_wdata       in   LINE_WIDTH  D-cache writeback line
//  d_rdata       out  LINE_WIDTH  line returned to D-cache (valid with d_resp)
//  d_resp        out  1           one-cycle D-cache completion pulse
//  l2_read       out  1           read request to L2 cache
//  l2_write      out  1           write request to L2 cache
//  l2_address    out  ADDR_WIDTH  latched address of granted requester
//  l2_wdata      out  LINE_WIDTH  latched write line of granted requester
//  l2_rdata      in   LINE_WIDTH  L2 read line (valid with l2_resp)
//  l2_resp       in   1           one-cycle L2 completion pulse
// BEHAVIOUR
//  Reset: state=IDLE, d_streak=0, addr/wdata regs=0; all out pulses/requests 0; rdata outs = l2_rdata.
//  States: IDLE, GNT_I, GNT_D, DONE.
//  IDLE: if no request, stay. Otherwise pick winner, latch address (and d_wdata, op) on this edge:
//   - only I pending -> GNT_I; only D pending -> GNT_D.
//   - both pending -> GNT_D unless d_streak == MAX_D_STREAK, then GNT_I.
//  d_streak: +1 (saturating at MAX_D_STREAK) on each D grant made while i_read is high;
//   cleared on every I grant and on any D grant made while i_read is low.
//  GNT_I: l2_read=1, l2_write=0. GNT_D: l2_read=latched read op, l2_write=latched write op.
//   L2 request driven from latched regs only; L1 input changes during a grant are ignored.
//  On l2_resp in GNT_x: x_resp=1 in the same cycle (combinational), x_rdata=l2_rdata; -> DONE.
//   The non-granted resp stays 0. The L2 request stays asserted during the l2_resp cycle.
//  DONE: l2_read=l2_write=0 for exactly one cycle (lets L2 controller return to idle and the
//   served L1 drop its request); no arbitration in DONE; -> IDLE.
//  Latency: request in IDLE at cycle N -> l2_read/l2_write high from cycle N+1; earliest new
//   grant after a response is two cycles after the l2_resp cycle.
//  d_read & d_write both high: illegal from D-cache; write wins (l2_write=1, l2_read=0).
//  Requester arriving while busy: waits, no loss; L1s hold request level until their resp.
//  l2_resp in IDLE or DONE: ignored, no resp forwarded.
//  rst mid-transaction: immediate return to IDLE, requests dropped, no resp emitted; the L2
//   is reset on the same rst and no partial transaction is resumed.
// TESTING
//  I-only read 0x0000_1000, L2 resp after 5 cycles -> l2_read 1 from N+1, i_resp 1 cycle, i_rdata=line.
//  D write 0x0000_2020 data 0xA5.. -> l2_write=1, l2_address=0x2020, l2_wdata=0xA5.., d_resp once.
//  I and D both request in same IDLE cycle -> D served first, then I; i_resp never with d_resp.
//  I held while D requests back-to-back, MAX_D_STREAK=4 -> exactly 4 D grants, then I granted.
//  Change d_address during GNT_D -> l2_address keeps latched value; DONE drops l2 req for 1 cycle.
//  Assert rst 2 cycles into GNT_I -> next cycle IDLE, l2_read=0, i_resp never pulses.

Source files
------------

// File: rtl/l2_request_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l2_request_arbiter: shares one L2 port between I-cache and D-cache misses |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module l2_request_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int LINE_WIDTH   = 256,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [ADDR_WIDTH-1:0] l2_address,
   output logic [LINE_WIDTH-1:0] l2_wdata,
   input  logic [LINE_WIDTH-1:0] l2_rdata,
   input  logic                  l2_resp
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_gnt_i = 2'd1;
   localparam logic [1:0] c_gnt_d = 2'd2;
   localparam logic [1:0] c_done  = 2'd3;

   localparam int              c_sw         = $clog2(MAX_D_STREAK + 1);
   localparam logic [c_sw-1:0] c_max_streak = c_sw'(MAX_D_STREAK);

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [c_sw-1:0]       r_d_streak;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;
   logic                  r_op_read;
   logic                  r_op_write;
   logic                  w_d_req;
   logic                  w_grant_i;
   logic                  w_grant_d;

   // D normally wins a tie; I is forced once D has monopolised the port.
   assign w_d_req   = d_read | d_write;
   assign w_grant_i = (r_state == c_idle) && i_read && (!w_d_req || (r_d_streak == c_max_streak));
   assign w_grant_d = (r_state == c_idle) && w_d_req && !w_grant_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_d_streak <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_op_read  <= 1'b0;
         r_op_write <= 1'b0;
      end else if (w_grant_i) begin
         r_d_streak <= '0;
         r_addr     <= i_address;
         r_op_read  <= 1'b1;
         r_op_write <= 1'b0;
      end else if (w_grant_d) begin
         r_addr     <= d_address;
         r_wdata    <= d_wdata;
         r_op_write <= d_write;
         r_op_read  <= d_read & ~d_write;
         if (!i_read) begin
            r_d_streak <= '0;
         end else if (r_d_streak != c_max_streak) begin
            r_d_streak <= r_d_streak + 1'b1;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_idle: begin
            if (w_grant_i) begin
               w_next_state = c_gnt_i;
            end else if (w_grant_d) begin
               w_next_state = c_gnt_d;
            end
         end
         c_gnt_i: if (l2_resp) w_next_state = c_done;
         c_gnt_d: if (l2_resp) w_next_state = c_done;
         c_done:  w_next_state = c_idle;
         default: w_next_state = c_idle;
      endcase
   end

   always_comb begin
      l2_read  = 1'b0;
      l2_write = 1'b0;
      i_resp   = 1'b0;
      d_resp   = 1'b0;
      case (r_state)
         c_gnt_i: begin
            l2_read = 1'b1;
            i_resp  = l2_resp;
         end
         c_gnt_d: begin
            l2_read  = r_op_read;
            l2_write = r_op_write;
            d_resp   = l2_resp;
         end
         default: ;
      endcase
   end

   assign l2_address = r_addr;
   assign l2_wdata   = r_wdata;
   assign i_rdata    = l2_rdata;
   assign d_rdata    = l2_rdata;

endmodule
`default_nettype wire
